// File: rtl/param_stack_pkg.sv
// ============================================================================
//  Module      : param_stack_pkg
//  Description : Shared operation encoding and width helper for param_stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_t;

    // Bits needed to encode 0..value-1, never less than one bit.
    function automatic int clog2_safe(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
// ============================================================================
//  Module      : stack_mem
//  Description : DEPTH x DATA_WIDTH register array, one synchronous write
//                port and one asynchronous read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (i_wr_en && (i_wr_addr <= c_last_addr)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-power-of-2 depths leave unused address codes; they read as zero.
    assign o_rd_data = (i_rd_addr <= c_last_addr) ? r_mem[i_rd_addr] : '0;

endmodule

`default_nettype wire

// File: rtl/param_stack.sv
// ============================================================================
//  Module      : param_stack
//  Description : Parametrised LIFO with replace, occupancy count, almost-full
//                threshold, sticky error flags and registered pop data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_stack
    import param_stack_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 8,
    parameter int ALMOST_FULL_TH = DEPTH - 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             push,
    input  logic                             pop,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             clear_err,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_valid,
    output logic [DATA_WIDTH-1:0]            top_out,
    output logic [clog2_safe(DEPTH+1)-1:0]   count,
    output logic                             stack_empty,
    output logic                             stack_full,
    output logic                             almost_full,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int CNT_W = clog2_safe(DEPTH + 1);
    localparam int IDX_W = clog2_safe(DEPTH);

    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_af_count   = CNT_W'(ALMOST_FULL_TH);

    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    stack_op_t             w_op;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_do_push;
    logic                  w_do_pop;
    logic                  w_do_replace;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;
    logic                  w_clear;
    logic [IDX_W-1:0]      w_top_idx;
    logic [IDX_W-1:0]      w_wr_addr;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);
    assign w_top_idx = IDX_W'(r_count - CNT_W'(1));
    assign w_clear   = enable & clear_err;

    always_comb begin
        w_op = OP_IDLE;
        case ({push, pop})
            2'b10:   w_op = OP_PUSH;
            2'b01:   w_op = OP_POP;
            2'b11:   w_op = OP_REPLACE;
            default: w_op = OP_IDLE;
        endcase
    end

    // A replace on an empty stack degrades to a push plus a rejected pop.
    always_comb begin
        w_do_push    = 1'b0;
        w_do_pop     = 1'b0;
        w_do_replace = 1'b0;
        w_ovf_evt    = 1'b0;
        w_unf_evt    = 1'b0;
        if (enable) begin
            case (w_op)
                OP_PUSH: begin
                    if (w_full) w_ovf_evt = 1'b1;
                    else        w_do_push = 1'b1;
                end
                OP_POP: begin
                    if (w_empty) w_unf_evt = 1'b1;
                    else         w_do_pop  = 1'b1;
                end
                OP_REPLACE: begin
                    if (w_empty) begin
                        w_do_push = 1'b1;
                        w_unf_evt = 1'b1;
                    end else begin
                        w_do_replace = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_wr_en   = (w_do_push | w_do_replace) & ~reset;
    assign w_wr_addr = w_do_replace ? w_top_idx : IDX_W'(r_count);

    stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (IDX_W)
    ) u_stack_mem (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (w_wr_addr),
        .i_wr_data  (data_in),
        .i_rd_addr  (w_top_idx),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_data_valid <= w_do_pop | w_do_replace;
            if (w_do_pop | w_do_replace) begin
                r_data_out <= w_rd_data;
            end
            if (w_do_push) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            // An error raised in the clearing cycle survives the clear.
            r_overflow  <= (r_overflow  & ~w_clear) | w_ovf_evt;
            r_underflow <= (r_underflow & ~w_clear) | w_unf_evt;
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign top_out     = w_empty ? '0 : w_rd_data;
    assign count       = r_count;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign almost_full = (r_count >= c_af_count);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

`default_nettype wire
